// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer: state codes, the state enum and the
// lock-loss counter ceiling. Imported by the sequencer RTL and by its bench.
package pll_lock_sequencer_pkg;

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABILIZE = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

    typedef enum logic [2:0] {
        StPllRst    = ST_PLL_RST,
        StWaitLock  = ST_WAIT_LOCK,
        StStabilize = ST_STABILIZE,
        StRun       = ST_RUN,
        StFault     = ST_FAULT
    } seq_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == LOSS_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and status signals of the lock sequencer. The sequencer uses the master modport;
// the surrounding logic (or a bench) uses slave.
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       retry;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [3:0] attempt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;

    modport master (
        input  pll_locked, retry,
        output pll_resetb, sys_reset, ready, fault, attempt, lock_loss_cnt, state
    );

    modport slave (
        output pll_locked, retry,
        input  pll_resetb, sys_reset, ready, fault, attempt, lock_loss_cnt, state
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for signals asynchronous to clk; both stages clear on synchronous reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: PLL reset, lock wait with timeout/retry, lock qualification, then
// release of sys_reset. Define PLL_SEQ_RELOCK_EN to re-run bring-up on lock loss instead of faulting.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 160000,
    parameter int unsigned STABLE_CYCLES       = 1024,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    pll_lock_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RetryMax    = 4'(MAX_RETRIES);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       attempt_q, attempt_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_resetb_q, sys_reset_q, ready_q, fault_q;
    logic             locked_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        attempt_d = attempt_q;
        loss_d    = loss_q;
        unique case (state_q)
            StPllRst: begin
                if (cnt_q == RstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end
            StWaitLock: begin
                // Lock is checked first so it wins over a coincident timeout.
                if (locked_s) begin
                    state_d = StStabilize;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d = '0;
                    if (attempt_q == RetryMax) begin
                        state_d = StFault;
                    end else begin
                        attempt_d = attempt_q + 4'd1;
                        state_d   = StPllRst;
                    end
                end
            end
            StStabilize: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d   = StRun;
                    cnt_d     = '0;
                    attempt_d = 4'd0;
                end
            end
            StRun: begin
                cnt_d = '0;
                if (!locked_s) begin
                    loss_d = sat_inc8(loss_q);
`ifdef PLL_SEQ_RELOCK_EN
                    state_d   = StPllRst;
                    attempt_d = 4'd0;
`else
                    state_d = StFault;
`endif
                end
            end
            StFault: begin
                cnt_d = '0;
                if (bus.retry) begin
                    state_d   = StPllRst;
                    attempt_d = 4'd0;
                end
            end
            default: begin
                state_d = StPllRst;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StPllRst;
            cnt_q        <= '0;
            attempt_q    <= 4'd0;
            loss_q       <= 8'd0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            attempt_q    <= attempt_d;
            loss_q       <= loss_d;
            // Outputs decoded from the next state so they change together with it.
            pll_resetb_q <= (state_d != StPllRst) && (state_d != StFault);
            sys_reset_q  <= (state_d != StRun);
            ready_q      <= (state_d == StRun);
            fault_q      <= (state_d == StFault);
        end
    end

    assign bus.pll_resetb    = pll_resetb_q;
    assign bus.sys_reset     = sys_reset_q;
    assign bus.ready         = ready_q;
    assign bus.fault         = fault_q;
    assign bus.attempt       = attempt_q;
    assign bus.lock_loss_cnt = loss_q;
    assign bus.state         = state_q;

endmodule
